rdmx_addr_gen: RTL and testbench
================================

RDMX_ADDR_GEN -- requirements
Module: rdmx_addr_gen

Interface
REQ-001 SHALL have: clk  in  1  clock; resetn  in  1  synchronous active-low reset.
REQ-002 SHALL have: RFD_ADDR, RFD_SIZE, RMD_ADDR, RMD_SIZE, RFC_ADDR  in  64 each  ring bases/sizes and frame-counter address (bytes).
REQ-003 SHALL have: FRAME_SIZE  in  32  bytes/frame; PACKET_SIZE  in  16  bytes/packet; PACKETS_PER_GROUP  in  32  data packets per metadata record.
REQ-004 SHALL have: start  in  1  single-cycle pulse that latches config and begins operation.
REQ-005 SHALL have: pkt_valid  in  1; pkt_ready  out  1  (packet-request handshake, one request per outgoing data packet).
REQ-006 SHALL have: out_valid  out  1; out_ready  in  1; out_addr  out  64; out_len  out  16; out_type  out  2 (0=DATA, 1=META, 2=CNTR); out_data  out  32.
REQ-007 SHALL have: frame_count  out  32  completed frames; busy  out  1  state != IDLE; cfg_err  out  1  sticky config error.

Function
REQ-008 SHALL use states IDLE, DATA, META, CNTR; start in IDLE moves to DATA next cycle, is ignored elsewhere.
REQ-009 On start, SHALL latch all config inputs into internal copies and clear data offset, meta offset, frame-byte and group counters; later config changes have no effect until the next start.
REQ-010 On start with PACKET_SIZE=0, FRAME_SIZE=0 or RFD_SIZE<PACKET_SIZE, SHALL set cfg_err and stay in IDLE.
REQ-011 PACKETS_PER_GROUP=0 SHALL be treated as 1.
REQ-012 Output beat SHALL be registered: out_valid holds with stable payload until out_ready; a new beat loads only when !out_valid or out_ready.
REQ-013 pkt_ready SHALL be 1 only in DATA when the output register can load this cycle.
REQ-014 On pkt handshake SHALL emit DATA beat: addr=RFD_ADDR+data_off, len=min(PACKET_SIZE, FRAME_SIZE-frame_bytes), data=0; next cycle's beat is visible (1-cycle latency).
REQ-015 data_off SHALL advance by len; if data_off+len+PACKET_SIZE > RFD_SIZE, data_off SHALL wrap to 0.
REQ-016 After DATA beat making group count reach PACKETS_PER_GROUP, SHALL go to META; group count clears.
REQ-017 After DATA beat completing FRAME_SIZE bytes, SHALL go to META (partial group flushed) regardless of group count, then CNTR.
REQ-018 META beat: addr=RMD_ADDR+meta_off, len=64, data=frame_count; meta_off advances 64, wraps to 0 when meta_off+128 > RMD_SIZE; return to DATA unless frame ended.
REQ-019 CNTR beat: addr=RFC_ADDR, len=4, data=frame_count+1; on its load frame_count increments, frame_bytes clears, state returns DATA.
REQ-020 Group end and frame end on the same packet SHALL produce exactly one META then CNTR.
REQ-021 Arithmetic SHALL be 64-bit unsigned for addresses, 32-bit for byte counts; no overflow wrap of frame_count beyond 2^32-1 (natural wrap permitted).

Reset
REQ-022 On resetn=0: state IDLE, out_valid=0, pkt_ready=0, out_addr/out_len/out_type/out_data=0, frame_count=0, cfg_err=0, all offsets/counters 0.
REQ-023 Reset mid-operation SHALL drop any pending beat with no handshake completion.

Configuration
REQ-024 Macro RDMX_FRAME_CNTR_EN: defined -> CNTR state and beats per REQ-019; undefined -> no CNTR beat, frame end goes META->DATA, frame_count still increments on META load at frame end.

Verification
REQ-025 PACKET_SIZE=256, FRAME_SIZE=1024, PPG=2, RFD_ADDR=0x1000 -> DATA 0x1000,0x1100, META, DATA 0x1200,0x1300, META, CNTR data=1.
REQ-026 FRAME_SIZE=600, PACKET_SIZE=256 -> DATA lens 256,256,88, then META, CNTR.
REQ-027 RFD_SIZE=0x300, PACKET_SIZE=256, 4 packets -> offsets 0x000,0x100,0x200,0x000.
REQ-028 out_ready=0 for 5 cycles with beat pending -> out_valid held, payload stable, pkt_ready=0.
REQ-029 start with PACKET_SIZE=0 -> cfg_err=1, busy=0, no beats.
REQ-030 resetn=0 during META with out_valid=1 -> next cycle out_valid=0, frame_count=0, state IDLE.

Source files
------------

// File: rtl/rdmx_addr_gen.sv
// rdmx_addr_gen -- address/descriptor generator for a receive DMA engine.
//
// Each outgoing data packet is requested with a pkt_valid/pkt_ready
// handshake. For each packet the block emits one DATA beat that addresses
// the data ring. After every PACKETS_PER_GROUP data packets it emits a META
// beat that addresses the metadata ring. At each frame end it flushes a
// META beat and then a CNTR beat. The CNTR beat is a 4-byte write of the
// completed-frame count to RFC_ADDR.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   RFD_ADDR/RFD_SIZE   data ring base and size (bytes)
//   RMD_ADDR/RMD_SIZE   metadata ring base and size (bytes)
//   RFC_ADDR            frame-counter write address
//   FRAME_SIZE          bytes per frame
//   PACKET_SIZE         bytes per data packet
//   PACKETS_PER_GROUP   data packets per metadata record (0 acts as 1)
//   start               pulse in IDLE: latch config and begin operation
//   pkt_valid/ready     per-packet request handshake
//   out_*               registered output beat (valid/ready handshake)
//                       out_type: 0=DATA, 1=META, 2=CNTR
//   frame_count         number of completed frames
//   busy                state is not IDLE
//   cfg_err             sticky: a start carried an unusable configuration
//
// Build option: RDMX_FRAME_CNTR_EN
//   defined   -> a CNTR beat follows the frame-end META beat.
//   undefined -> no CNTR beat. frame_count increments when the frame-end
//                META beat loads.

module rdmx_addr_gen (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] RFD_ADDR,
  input  logic [63:0] RFD_SIZE,
  input  logic [63:0] RMD_ADDR,
  input  logic [63:0] RMD_SIZE,
  input  logic [63:0] RFC_ADDR,
  input  logic [31:0] FRAME_SIZE,
  input  logic [15:0] PACKET_SIZE,
  input  logic [31:0] PACKETS_PER_GROUP,
  input  logic        start,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_addr,
  output logic [15:0] out_len,
  output logic [1:0]  out_type,
  output logic [31:0] out_data,
  output logic [31:0] frame_count,
  output logic        busy,
  output logic        cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_META = 2'd2,
    ST_CNTR = 2'd3
  } state_t;

  localparam logic [1:0] TYPE_DATA = 2'd0;
  localparam logic [1:0] TYPE_META = 2'd1;
`ifdef RDMX_FRAME_CNTR_EN
  localparam logic [1:0] TYPE_CNTR = 2'd2;
`endif

  state_t      state_q, state_d;

  // Configuration latched on start
  logic [63:0] rfd_addr_q, rfd_addr_d;
  logic [63:0] rfd_size_q, rfd_size_d;
  logic [63:0] rmd_addr_q, rmd_addr_d;
  logic [63:0] rmd_size_q, rmd_size_d;
  logic [31:0] frame_size_q, frame_size_d;
  logic [15:0] pkt_size_q, pkt_size_d;
  logic [31:0] ppg_q, ppg_d;
`ifdef RDMX_FRAME_CNTR_EN
  logic [63:0] rfc_addr_q, rfc_addr_d;
`else
  logic        unused_rfc;
  assign unused_rfc = &{1'b0, RFC_ADDR};
`endif

  // Progress counters
  logic [63:0] data_off_q, data_off_d;
  logic [63:0] meta_off_q, meta_off_d;
  logic [31:0] frame_bytes_q, frame_bytes_d;
  logic [31:0] group_q, group_d;
  logic        frame_end_q, frame_end_d;   // META in flight is a frame-end flush
  logic [31:0] frame_count_q, frame_count_d;
  logic        cfg_err_q, cfg_err_d;

  // Output beat register
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_addr_q, out_addr_d;
  logic [15:0] out_len_q, out_len_d;
  logic [1:0]  out_type_q, out_type_d;
  logic [31:0] out_data_q, out_data_d;

  // Datapath helpers
  logic        can_load;
  logic [31:0] remaining;
  logic [15:0] data_len;
  logic [63:0] off_adv;
  logic        data_wrap;
  logic [31:0] fb_sum;
  logic        frame_done;
  logic [31:0] group_inc;
  logic        group_done;
  logic        meta_wrap;
  logic        start_err;

  assign can_load   = !out_valid_q || out_ready;
  assign remaining  = frame_size_q - frame_bytes_q;
  // The last packet of a frame is truncated to the bytes left in the frame.
  assign data_len   = (remaining < {16'd0, pkt_size_q}) ? remaining[15:0] : pkt_size_q;
  assign off_adv    = data_off_q + {48'd0, data_len};
  // Wrap early when the next full packet would no longer fit in the ring.
  assign data_wrap  = (off_adv + {48'd0, pkt_size_q}) > rfd_size_q;
  assign fb_sum     = frame_bytes_q + {16'd0, data_len};
  assign frame_done = fb_sum >= frame_size_q;
  assign group_inc  = group_q + 32'd1;
  assign group_done = group_inc >= ppg_q;
  assign meta_wrap  = (meta_off_q + 64'd128) > rmd_size_q;
  assign start_err  = (PACKET_SIZE == 16'd0) || (FRAME_SIZE == 32'd0) ||
                      (RFD_SIZE < {48'd0, PACKET_SIZE});

  always_comb begin
    state_d       = state_q;
    rfd_addr_d    = rfd_addr_q;
    rfd_size_d    = rfd_size_q;
    rmd_addr_d    = rmd_addr_q;
    rmd_size_d    = rmd_size_q;
    frame_size_d  = frame_size_q;
    pkt_size_d    = pkt_size_q;
    ppg_d         = ppg_q;
`ifdef RDMX_FRAME_CNTR_EN
    rfc_addr_d    = rfc_addr_q;
`endif
    data_off_d    = data_off_q;
    meta_off_d    = meta_off_q;
    frame_bytes_d = frame_bytes_q;
    group_d       = group_q;
    frame_end_d   = frame_end_q;
    frame_count_d = frame_count_q;
    cfg_err_d     = cfg_err_q;
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;
    out_len_d     = out_len_q;
    out_type_d    = out_type_q;
    out_data_d    = out_data_q;

    // Consumed beat retires unless a new one replaces it below
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_err) begin
            cfg_err_d = 1'b1;
          end else begin
            rfd_addr_d    = RFD_ADDR;
            rfd_size_d    = RFD_SIZE;
            rmd_addr_d    = RMD_ADDR;
            rmd_size_d    = RMD_SIZE;
            frame_size_d  = FRAME_SIZE;
            pkt_size_d    = PACKET_SIZE;
            ppg_d         = (PACKETS_PER_GROUP == 32'd0) ? 32'd1 : PACKETS_PER_GROUP;
`ifdef RDMX_FRAME_CNTR_EN
            rfc_addr_d    = RFC_ADDR;
`endif
            data_off_d    = 64'd0;
            meta_off_d    = 64'd0;
            frame_bytes_d = 32'd0;
            group_d       = 32'd0;
            frame_end_d   = 1'b0;
            state_d       = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (pkt_valid && can_load) begin
          out_valid_d   = 1'b1;
          out_addr_d    = rfd_addr_q + data_off_q;
          out_len_d     = data_len;
          out_type_d    = TYPE_DATA;
          out_data_d    = 32'd0;
          data_off_d    = data_wrap ? 64'd0 : off_adv;
          frame_bytes_d = fb_sum;
          // A group end and a frame end on the same packet share one META.
          if (frame_done || group_done) begin
            group_d     = 32'd0;
            frame_end_d = frame_done;
            state_d     = ST_META;
          end else begin
            group_d     = group_inc;
          end
        end
      end

      ST_META: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_addr_d  = rmd_addr_q + meta_off_q;
          out_len_d   = 16'd64;
          out_type_d  = TYPE_META;
          out_data_d  = frame_count_q;
          meta_off_d  = meta_wrap ? 64'd0 : (meta_off_q + 64'd64);
`ifdef RDMX_FRAME_CNTR_EN
          state_d     = frame_end_q ? ST_CNTR : ST_DATA;
`else
          if (frame_end_q) begin
            frame_count_d = frame_count_q + 32'd1;
            frame_bytes_d = 32'd0;
            frame_end_d   = 1'b0;
          end
          state_d     = ST_DATA;
`endif
        end
      end

`ifdef RDMX_FRAME_CNTR_EN
      ST_CNTR: begin
        if (can_load) begin
          out_valid_d   = 1'b1;
          out_addr_d    = rfc_addr_q;
          out_len_d     = 16'd4;
          out_type_d    = TYPE_CNTR;
          out_data_d    = frame_count_q + 32'd1;
          frame_count_d = frame_count_q + 32'd1;
          frame_bytes_d = 32'd0;
          frame_end_d   = 1'b0;
          state_d       = ST_DATA;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      rfd_addr_q    <= 64'd0;
      rfd_size_q    <= 64'd0;
      rmd_addr_q    <= 64'd0;
      rmd_size_q    <= 64'd0;
      frame_size_q  <= 32'd0;
      pkt_size_q    <= 16'd0;
      ppg_q         <= 32'd1;
`ifdef RDMX_FRAME_CNTR_EN
      rfc_addr_q    <= 64'd0;
`endif
      data_off_q    <= 64'd0;
      meta_off_q    <= 64'd0;
      frame_bytes_q <= 32'd0;
      group_q       <= 32'd0;
      frame_end_q   <= 1'b0;
      frame_count_q <= 32'd0;
      cfg_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= 64'd0;
      out_len_q     <= 16'd0;
      out_type_q    <= 2'd0;
      out_data_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      rfd_addr_q    <= rfd_addr_d;
      rfd_size_q    <= rfd_size_d;
      rmd_addr_q    <= rmd_addr_d;
      rmd_size_q    <= rmd_size_d;
      frame_size_q  <= frame_size_d;
      pkt_size_q    <= pkt_size_d;
      ppg_q         <= ppg_d;
`ifdef RDMX_FRAME_CNTR_EN
      rfc_addr_q    <= rfc_addr_d;
`endif
      data_off_q    <= data_off_d;
      meta_off_q    <= meta_off_d;
      frame_bytes_q <= frame_bytes_d;
      group_q       <= group_d;
      frame_end_q   <= frame_end_d;
      frame_count_q <= frame_count_d;
      cfg_err_q     <= cfg_err_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_len_q     <= out_len_d;
      out_type_q    <= out_type_d;
      out_data_q    <= out_data_d;
    end
  end

  assign pkt_ready   = (state_q == ST_DATA) && can_load;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_len     = out_len_q;
  assign out_type    = out_type_q;
  assign out_data    = out_data_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != ST_IDLE);
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_rdmx_addr_gen.sv
module tb_rdmx_addr_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] rfd_addr = 64'd0, rfd_size = 64'd0, rmd_addr = 64'd0;
  logic [63:0] rmd_size = 64'd0, rfc_addr = 64'd0;
  logic [31:0] frame_size = 32'd0;
  logic [15:0] packet_size = 16'd0;
  logic [31:0] ppg = 32'd0;
  logic        start = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_addr;
  logic [15:0] out_len;
  logic [1:0]  out_type;
  logic [31:0] out_data;
  logic [31:0] frame_count;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] len;
    logic [1:0]  typ;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];

  rdmx_addr_gen dut (
    .clk(clk), .resetn(resetn),
    .RFD_ADDR(rfd_addr), .RFD_SIZE(rfd_size), .RMD_ADDR(rmd_addr),
    .RMD_SIZE(rmd_size), .RFC_ADDR(rfc_addr),
    .FRAME_SIZE(frame_size), .PACKET_SIZE(packet_size),
    .PACKETS_PER_GROUP(ppg), .start(start),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_len(out_len), .out_type(out_type),
    .out_data(out_data), .frame_count(frame_count), .busy(busy),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a negedge sample of the handshake
  // predicts the transfer at the following posedge.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready)
      q.push_back('{addr: out_addr, len: out_len, typ: out_type, data: out_data});
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0; start = 1'b0; pkt_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    q.delete();
  endtask

  task automatic set_cfg(input logic [63:0] fa, input logic [63:0] fs,
                         input logic [31:0] frs, input logic [15:0] ps,
                         input logic [31:0] g, input logic [63:0] msz);
    rfd_addr = fa; rfd_size = fs; frame_size = frs; packet_size = ps; ppg = g;
    rmd_addr = 64'h8000; rmd_size = msz; rfc_addr = 64'h9000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pop_beat(output beat_t b, output bit ok);
    ok = 1'b0;
    b = '0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() > 0) begin
        b = q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pops n beats and compares them against the expected tables.
  task automatic expect_beats(input string name, input int n,
                              input logic [63:0] ea[], input logic [15:0] el[],
                              input logic [1:0] et[], input logic [31:0] ed[]);
    beat_t b;
    bit ok;
    for (int i = 0; i < n; i++) begin
      pop_beat(b, ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL %s beat%0d timeout: got no beat, required a beat", name, i);
        return;
      end
      checks++;
      if (b.addr !== ea[i] || b.len !== el[i] || b.typ !== et[i] || b.data !== ed[i]) begin
        errors++;
        $display("FAIL %s beat%0d: got addr=%h len=%0d type=%0d data=%0d, required addr=%h len=%0d type=%0d data=%0d",
                 name, i, b.addr, b.len, b.typ, b.data, ea[i], el[i], et[i], ed[i]);
      end else begin
        $display("%s beat%0d addr=%h len=%0d type=%0d data=%0d ok", name, i, b.addr, b.len, b.typ, b.data);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, pkt_ready, busy, cfg_err} !== 4'b0000 || out_addr !== 64'd0 ||
        out_len !== 16'd0 || out_type !== 2'd0 || out_data !== 32'd0 || frame_count !== 32'd0) begin
      errors++;
      $display("FAIL reset: got v=%b pr=%b busy=%b err=%b addr=%h len=%0d type=%0d data=%0d fc=%0d, required all 0",
               out_valid, pkt_ready, busy, cfg_err, out_addr, out_len, out_type, out_data, frame_count);
    end else $display("reset state ok");
  endtask

  task automatic test_groups();
    logic [63:0] ea[] = '{64'h1000, 64'h1100, 64'h8000, 64'h1200, 64'h1300, 64'h8040,
`ifdef RDMX_FRAME_CNTR_EN
                          64'h9000};
    logic [15:0] el[] = '{16'd256, 16'd256, 16'd64, 16'd256, 16'd256, 16'd64, 16'd4};
    logic [1:0]  et[] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
    logic [31:0] ed[] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
`else
                          64'h1400};
    logic [15:0] el[] = '{16'd256, 16'd256, 16'd64, 16'd256, 16'd256, 16'd64, 16'd256};
    logic [1:0]  et[] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [31:0] ed[] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
    do_reset();
    set_cfg(64'h1000, 64'h10000, 32'd1024, 16'd256, 32'd2, 64'h1000);
    pulse_start();
    // Config changes after start must not matter
    rfd_addr = 64'hDEAD0000;
    packet_size = 16'd16;
    pkt_valid = 1'b1; out_ready = 1'b1;
    expect_beats("groups", 7, ea, el, et, ed);
    @(negedge clk);
    checks++;
    if (frame_count !== 32'd1) begin
      errors++;
      $display("FAIL groups frame_count: got %0d, required 1", frame_count);
    end else $display("groups frame_count=1 ok");
  endtask

  task automatic test_partial_frame();
    logic [63:0] ea[] = '{64'h0, 64'h100, 64'h200, 64'h8000,
`ifdef RDMX_FRAME_CNTR_EN
                          64'h9000};
    logic [15:0] el[] = '{16'd256, 16'd256, 16'd88, 16'd64, 16'd4};
    logic [1:0]  et[] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    logic [31:0] ed[] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
`else
                          64'h258};
    logic [15:0] el[] = '{16'd256, 16'd256, 16'd88, 16'd64, 16'd256};
    logic [1:0]  et[] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [31:0] ed[] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
    do_reset();
    set_cfg(64'h0, 64'h10000, 32'd600, 16'd256, 32'd32, 64'h1000);
    pulse_start();
    pkt_valid = 1'b1; out_ready = 1'b1;
    expect_beats("partial", 5, ea, el, et, ed);
  endtask

  task automatic test_data_wrap();
    logic [63:0] ea[] = '{64'h2000, 64'h2100, 64'h2200, 64'h2000};
    logic [15:0] el[] = '{16'd256, 16'd256, 16'd256, 16'd256};
    logic [1:0]  et[] = '{2'd0, 2'd0, 2'd0, 2'd0};
    logic [31:0] ed[] = '{32'd0, 32'd0, 32'd0, 32'd0};
    do_reset();
    set_cfg(64'h2000, 64'h300, 32'h100000, 16'd256, 32'd8, 64'h1000);
    pulse_start();
    pkt_valid = 1'b1; out_ready = 1'b1;
    expect_beats("dwrap", 4, ea, el, et, ed);
  endtask

  // PPG=0 acts as 1; RMD_SIZE=0xC0 wraps the meta offset after 0x80.
  task automatic test_ppg_zero_meta_wrap();
    logic [63:0] ea[] = '{64'h0, 64'h8000, 64'h10, 64'h8040, 64'h20, 64'h8080, 64'h30, 64'h8000};
    logic [15:0] el[] = '{16'd16, 16'd64, 16'd16, 16'd64, 16'd16, 16'd64, 16'd16, 16'd64};
    logic [1:0]  et[] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [31:0] ed[] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_reset();
    set_cfg(64'h0, 64'h10000, 32'h1000, 16'd16, 32'd0, 64'hC0);
    pulse_start();
    pkt_valid = 1'b1; out_ready = 1'b1;
    expect_beats("mwrap", 8, ea, el, et, ed);
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    do_reset();
    set_cfg(64'h1000, 64'h10000, 32'd1024, 16'd256, 32'd2, 64'h1000);
    pulse_start();
    pkt_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL stall first beat: got out_valid=0, required 1");
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 64'h1000 || out_len !== 16'd256 ||
          out_type !== 2'd0 || pkt_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cycle%0d: got v=%b addr=%h len=%0d type=%0d pr=%b, required v=1 addr=1000 len=256 type=0 pr=0",
                 c, out_valid, out_addr, out_len, out_type, pkt_ready);
      end else $display("stall cycle%0d held ok", c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 64'h1100) begin
      errors++;
      $display("FAIL stall release: got v=%b addr=%h, required v=1 addr=1100", out_valid, out_addr);
    end else $display("stall release next beat addr=%h ok", out_addr);
  endtask

  task automatic test_cfg_err(input string name, input logic [31:0] frs,
                              input logic [15:0] ps, input logic [63:0] fsz);
    bit any_valid = 1'b0;
    do_reset();
    set_cfg(64'h0, fsz, frs, ps, 32'd2, 64'h1000);
    pulse_start();
    pkt_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || any_valid !== 1'b0 || pkt_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got err=%b busy=%b beat=%b pr=%b, required err=1 busy=0 beat=0 pr=0",
               name, cfg_err, busy, any_valid, pkt_ready);
    end else $display("%s cfg_err=1 idle ok", name);
  endtask

  task automatic test_reset_during_meta();
    int metas = 0;
    bit found = 1'b0;
    do_reset();
    set_cfg(64'h0, 64'h10000, 32'd256, 16'd256, 32'd2, 64'h1000);
    pulse_start();
    pkt_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (out_valid && out_type == 2'd1) begin
        metas++;
        if (metas == 2) begin found = 1'b1; break; end
      end
      out_ready = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL rstmeta reach: got metas=%0d, required 2", metas);
    end
    checks++;
`ifdef RDMX_FRAME_CNTR_EN
    if (frame_count !== 32'd1) begin
      errors++;
      $display("FAIL rstmeta pre fc: got %0d, required 1", frame_count);
    end
`else
    if (frame_count !== 32'd2) begin
      errors++;
      $display("FAIL rstmeta pre fc: got %0d, required 2", frame_count);
    end
`endif
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || frame_count !== 32'd0 || busy !== 1'b0 ||
        pkt_ready !== 1'b0 || out_addr !== 64'd0) begin
      errors++;
      $display("FAIL rstmeta: got v=%b fc=%0d busy=%b pr=%b addr=%h, required all 0",
               out_valid, frame_count, busy, pkt_ready, out_addr);
    end else $display("rstmeta beat dropped, idle ok");
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_groups();
    test_partial_frame();
    test_data_wrap();
    test_ppg_zero_meta_wrap();
    test_backpressure();
    test_cfg_err("cfgerr_ps0", 32'd1024, 16'd0, 64'h10000);
    test_cfg_err("cfgerr_fs0", 32'd0, 16'd256, 64'h10000);
    test_cfg_err("cfgerr_ring", 32'd1024, 16'd256, 64'hFF);
    test_reset_during_meta();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
